mat_mult_sequencer: RTL and testbench
=====================================

MAT_MULT_SEQUENCER -- requirements
Module: mat_mult_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4: operand element width.
REQ-002 The block SHALL have parameter RES_W, default 8 (2*DATA_W): result element width.
REQ-003 The block SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1: operand set valid.
REQ-006 The block SHALL have port in_ready, output, 1: block can accept an operand set.
REQ-007 The block SHALL have ports a, b, c, d, input, DATA_W each: matrix A = [a b; c d].
REQ-008 The block SHALL have ports e, f, g, h, input, DATA_W each: matrix B = [e f; g h].
REQ-009 The block SHALL have port out_valid, output, 1: result valid.
REQ-010 The block SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 The block SHALL have ports w, x, y, z, output, RES_W each: result [w x; y z].
REQ-012 The block SHALL have port busy, output, 1: high in MUL or DONE.

Function
REQ-013 The block SHALL compute w=a*e+b*g, x=a*f+b*h, y=c*e+d*g, z=c*f+d*h, each sum truncated mod 2^RES_W.
REQ-014 The block SHALL time-share exactly one DATA_W x DATA_W multiplier across the 8 products.
REQ-015 The FSM SHALL have states IDLE, MUL, DONE; reset state IDLE.
REQ-016 in_ready SHALL be high only in IDLE; an input handshake (in_valid && in_ready) SHALL register a..h, clear the four accumulators, zero step counter, go to MUL.
REQ-017 In MUL, step k (0..7) SHALL add one product to accumulator k>>1 (0=w,1=x,2=y,3=z), term k&1 (0 = first product in REQ-013, 1 = second), one step per cycle.
REQ-018 After step 7 the FSM SHALL go to DONE; out_valid SHALL rise the cycle after step 7, i.e. 9 edges after the input handshake edge.
REQ-019 In DONE, w/x/y/z SHALL hold stable while out_valid && !out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; input changes during MUL SHALL NOT affect the result.
REQ-021 With in_valid and out_ready held high, one operand set SHALL be accepted every 10 cycles.
REQ-022 w/x/y/z SHALL retain the last result in IDLE until the next handshake clears them.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, step counter 0, registered operands 0, w=x=y=z=0, out_valid=0, busy=0; in_ready SHALL read 0 while rst_n is low and 1 from the first edge after release.
REQ-024 Reset during MUL or DONE SHALL abandon the operation with no output handshake.

Configuration
REQ-025 With MAT_SEQ_OVF_EN defined, an output port ovf [3:0] SHALL exist; bit i SHALL be set when accumulator i (0=w..3=z) wraps past 2^RES_W-1. It SHALL be cleared on input handshake and reset, and valid with out_valid.
REQ-026 Without MAT_SEQ_OVF_EN, no ovf port or overflow logic SHALL exist; the remaining behaviour SHALL be identical.

Structure
REQ-027 Package mat_seq_pkg SHALL hold the FSM state enum, NUM_STEPS=8, and element index constants W_IDX..Z_IDX.
REQ-028 The multiplier SHALL be a separate combinational sub-module mul_4x4 (DATA_W in, 2*DATA_W out), instantiated once.

Verification
REQ-029 The bench SHALL apply A=[1 2;3 4], B=[1 0;0 1], out_ready=1 -> w=1 x=2 y=3 z=4, out_valid rises 9 edges after the handshake, and ovf=0.
REQ-030 The bench SHALL apply all elements 15 -> w=x=y=z=194 (450 mod 256); ovf=4'b1111 when MAT_SEQ_OVF_EN is defined.
REQ-031 The bench SHALL apply A=[2 3;4 5], B=[6 7;8 9] with out_ready low for 5 cycles in DONE -> w=36 x=41 y=64 z=73 stable, in_ready=0 throughout, and one handshake when out_ready rises.
REQ-032 The bench SHALL assert rst_n low at MUL step 4 -> out_valid=0 and outputs 0 at once; after release the next set A=[1 1;1 1], B=[1 1;1 1] gives w=x=y=z=2.
REQ-033 The bench SHALL hold in_valid=1 and out_ready=1 with operands changing every cycle -> accepts every 10 cycles, and each result matches the operands sampled at its handshake.

Source files
------------

// File: rtl/mat_seq_pkg.sv
// rtl/mat_seq_pkg.sv - shared types and constants for the 2x2 matrix multiply sequencer
package mat_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_STEPS = 8;
  localparam int STEP_W    = $clog2(NUM_STEPS);

  localparam int W_IDX = 0;
  localparam int X_IDX = 1;
  localparam int Y_IDX = 2;
  localparam int Z_IDX = 3;

endpackage

// File: rtl/mul_4x4.sv
// rtl/mul_4x4.sv - combinational unsigned DATA_W x DATA_W multiplier
module mul_4x4 #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] p_o
);

  assign p_o = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

endmodule

// File: rtl/mat_mult_sequencer.sv
// rtl/mat_mult_sequencer.sv - 2x2 matrix multiply using one shared multiplier over 8 steps
// Optional overflow flags on port ovf when MAT_SEQ_OVF_EN is defined.
module mat_mult_sequencer
  import mat_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  w,
  output logic [RES_W-1:0]  x,
  output logic [RES_W-1:0]  y,
  output logic [RES_W-1:0]  z,
`ifdef MAT_SEQ_OVF_EN
  output logic [3:0]        ovf,
`endif
  output logic              busy
);

`ifdef MAT_SEQ_OVF_EN
  localparam int SUM_W = RES_W + 1;
`else
  localparam int SUM_W = RES_W;
`endif

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DATA_W-1:0]   op_a_q [4];
  logic [DATA_W-1:0]   op_a_d [4];
  logic [DATA_W-1:0]   op_b_q [4];
  logic [DATA_W-1:0]   op_b_d [4];
  logic [RES_W-1:0]    acc_q  [4];
  logic [RES_W-1:0]    acc_d  [4];
  logic                alive_q;
`ifdef MAT_SEQ_OVF_EN
  logic [3:0]          ovf_q, ovf_d;
`endif

  logic [DATA_W-1:0]   mul_a, mul_b;
  logic [2*DATA_W-1:0] prod;
  logic [1:0]          acc_idx;
  logic [SUM_W-1:0]    sum;
  logic                in_hs;

  // Step k: row k[2], column k[1], inner term k[0]; A is row-major {a,b,c,d}, B is {e,f,g,h}.
  assign acc_idx = step_q[2:1];
  assign mul_a   = op_a_q[{step_q[2], step_q[0]}];
  assign mul_b   = op_b_q[{step_q[0], step_q[1]}];
  assign sum     = SUM_W'(acc_q[acc_idx]) + SUM_W'(prod);

  mul_4x4 #(.DATA_W(DATA_W)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  // alive_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = alive_q && (state_q == ST_IDLE);
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MUL) || (state_q == ST_DONE);

  assign w = acc_q[W_IDX];
  assign x = acc_q[X_IDX];
  assign y = acc_q[Y_IDX];
  assign z = acc_q[Z_IDX];
`ifdef MAT_SEQ_OVF_EN
  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
`ifdef MAT_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          op_a_d  = '{a, b, c, d};
          op_b_d  = '{e, f, g, h};
          acc_d   = '{default: '0};
          step_d  = '0;
`ifdef MAT_SEQ_OVF_EN
          ovf_d   = '0;
`endif
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d[acc_idx] = sum[RES_W-1:0];
`ifdef MAT_SEQ_OVF_EN
        ovf_d[acc_idx] = ovf_q[acc_idx] | sum[RES_W];
`endif
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      alive_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
        acc_q[i]  <= '0;
      end
`ifdef MAT_SEQ_OVF_EN
      ovf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      alive_q <= 1'b1;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
`ifdef MAT_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mat_mult_sequencer.sv
// tb/tb_mat_mult_sequencer.sv - self-checking bench for mat_mult_sequencer
module tb_mat_mult_sequencer;

  localparam int DW = 4;
  localparam int RW = 8;

  typedef logic [7:0][DW-1:0] opset_t;   // [0]=a .. [3]=d, [4]=e .. [7]=h

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0, h = '0;
  logic          in_ready, out_valid, busy;
  logic [RW-1:0] w, x, y, z;
`ifdef MAT_SEQ_OVF_EN
  logic [3:0]    ovf;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic armed = 1'b0;
  logic streaming = 1'b0;

  mat_mult_sequencer #(.DATA_W(DW), .RES_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
`ifdef MAT_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Full (unwrapped) matrix product element i of A*B, i = row*2+col.
  function automatic int full_elem(input opset_t s, input int i);
    int row = i / 2;
    int col = i % 2;
    int acc = 0;
    for (int t = 0; t < 2; t++) acc += int'(s[2*row + t]) * int'(s[4 + 2*t + col]);
    return acc;
  endfunction

  function automatic int res_elem(input opset_t s, input int i);
    return full_elem(s, i) % (1 << RW);
  endfunction

  function automatic opset_t mk(input int va, vb, vc, vd, ve, vf, vg, vh);
    opset_t s;
    s[0] = DW'(va); s[1] = DW'(vb); s[2] = DW'(vc); s[3] = DW'(vd);
    s[4] = DW'(ve); s[5] = DW'(vf); s[6] = DW'(vg); s[7] = DW'(vh);
    return s;
  endfunction

  function automatic int dut_elem(input int i);
    case (i)
      0: return int'(w);
      1: return int'(x);
      2: return int'(y);
      default: return int'(z);
    endcase
  endfunction

  // Scoreboard: accepted-but-undelivered sets, last delivered result.
  opset_t q[$];
  int     last_res[4] = '{0, 0, 0, 0};
  int     hs_cyc = 0;
  int     last_push = 0;
  logic   have_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_res  = '{0, 0, 0, 0};
      have_prev = 1'b0;
    end else begin
      logic exp_ov;
      exp_ov = (q.size() != 0) && ((cyc - hs_cyc + 1) >= 9);
      chk("busy", int'(busy), int'(q.size() != 0));
      chk("in_ready", int'(in_ready), int'(armed && q.size() == 0));
      chk("out_valid", int'(out_valid), int'(exp_ov));
      if (q.size() == 0) begin
        for (int i = 0; i < 4; i++) chk($sformatf("idle_hold[%0d]", i), dut_elem(i), last_res[i]);
      end else if (exp_ov && out_valid) begin
        for (int i = 0; i < 4; i++) chk($sformatf("result[%0d]", i), dut_elem(i), res_elem(q[0], i));
`ifdef MAT_SEQ_OVF_EN
        for (int i = 0; i < 4; i++) chk($sformatf("ovf[%0d]", i), int'(ovf[i]), int'(full_elem(q[0], i) >= (1 << RW)));
`endif
      end
      if (in_valid && in_ready) begin
        if (streaming && have_prev) chk("accept_interval", cyc + 1 - last_push, 10);
        have_prev = streaming;
        last_push = cyc + 1;
        hs_cyc    = cyc + 1;
        q.push_back({h, g, f, e, d, c, b, a});
      end
      if (out_valid && out_ready && q.size() != 0) begin
        for (int i = 0; i < 4; i++) last_res[i] = res_elem(q[0], i);
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input opset_t s);
    int n = 0;
    {h, g, f, e, d, c, b, a} = s;
    in_valid = 1'b1;
    while (n < 30) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("send_timeout", int'(n >= 30), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns edges counted from the handshake edge (inclusive) until out_valid is seen high.
  task automatic wait_ov(output int n);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk("out_valid_timeout", int'(n >= 40), 0);
  endtask

  task automatic chk_lit(input string nm, input int ew, ex, ey, ez);
    chk({nm, "_w"}, int'(w), ew);
    chk({nm, "_x"}, int'(x), ex);
    chk({nm, "_y"}, int'(y), ey);
    chk({nm, "_z"}, int'(z), ez);
  endtask

  initial begin
    int n;
    opset_t s;

    // Pin the model against hand-computed values.
    chk("model_id_w", res_elem(mk(1, 2, 3, 4, 1, 0, 0, 1), 0), 1);
    chk("model_id_z", res_elem(mk(1, 2, 3, 4, 1, 0, 0, 1), 3), 4);
    chk("model_15_x", res_elem(mk(15, 15, 15, 15, 15, 15, 15, 15), 1), 194);
    chk("model_2345_y", res_elem(mk(2, 3, 4, 5, 6, 7, 8, 9), 2), 64);
    chk("model_2345_z", res_elem(mk(2, 3, 4, 5, 6, 7, 8, 9), 3), 73);

    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk_lit("rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", int'(in_ready), 1);

    // Identity B, latency check.
    out_ready = 1'b1;
    send(mk(1, 2, 3, 4, 1, 0, 0, 1));
    wait_ov(n);
    chk("latency_edges", n, 9);
    chk_lit("ident", 1, 2, 3, 4);
`ifdef MAT_SEQ_OVF_EN
    chk("ident_ovf", int'(ovf), 0);
`endif
    @(posedge clk); #1;

    // All 15: every sum 450 wraps to 194.
    send(mk(15, 15, 15, 15, 15, 15, 15, 15));
    wait_ov(n);
    chk_lit("all15", 194, 194, 194, 194);
`ifdef MAT_SEQ_OVF_EN
    chk("all15_ovf", int'(ovf), 15);
`endif
    @(posedge clk); #1;

    // Back-pressure in DONE for 5 cycles.
    out_ready = 1'b0;
    send(mk(2, 3, 4, 5, 6, 7, 8, 9));
    wait_ov(n);
    for (int i = 0; i < 5; i++) begin
      chk_lit("stall", 36, 41, 64, 73);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    chk("after_hs_out_valid", int'(out_valid), 0);
    chk("after_hs_in_ready", int'(in_ready), 1);
    chk_lit("retain", 36, 41, 64, 73);
    @(negedge clk);
    chk("single_hs", int'(out_valid), 0);

    // Reset in the middle of MUL (step 4).
    send(mk(3, 1, 2, 5, 4, 6, 7, 1));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk_lit("midrst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("midrst_rel_in_ready", int'(in_ready), 0);
    send(mk(1, 1, 1, 1, 1, 1, 1, 1));
    wait_ov(n);
    chk("postrst_latency", n, 9);
    chk_lit("ones", 2, 2, 2, 2);
    @(posedge clk); #1;

    // Streaming: operands change every cycle, in_valid/out_ready held high.
    streaming = 1'b1;
    in_valid  = 1'b1;
    for (int cnum = 0; cnum < 56; cnum++) begin
      for (int k = 0; k < 8; k++) s[k] = DW'($urandom_range(0, 15));
      {h, g, f, e, d, c, b, a} = s;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    streaming = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", int'(n >= 30), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
